// File: rtl/rx_fifo.sv
// rx_fifo: receive buffer between the UART RX datapath and the host.
// Each completed word (rxData with a one-cycle rxLoad strobe) is written into
// a circular FIFO. The host reads words over a valid/ready handshake, with
// first-word-fall-through on dataOut.
//
// Ports:
//   sampleClk   in   block clock (same clock as the RX datapath)
//   rst_b       in   asynchronous active-low reset
//   rxData      in   received word
//   rxLoad      in   write strobe for rxData
//   dataOut     out  head-of-FIFO word, 0 when empty
//   dataValid   out  dataOut holds a valid word
//   dataReady   in   host accepts dataOut when dataValid is high
//   full        out  all depth entries occupied
//   empty       out  no entries occupied
//   count       out  occupancy, 0..depth
//   overrun     out  sticky: a write was dropped because the FIFO was full
//   clrOverrun  in   synchronous clear of overrun
//   almostFull  out  only with RX_FIFO_ALMOST_FULL_EN: registered,
//                    high when the next-state count >= afThresh
//
// Optional feature macro: RX_FIFO_ALMOST_FULL_EN
module rx_fifo #(
  parameter int wordSize = 8,
  parameter int depth    = 8,
  parameter int addrBits = 3
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int afThresh = depth - 2
`endif
) (
  input  logic                sampleClk,
  input  logic                rst_b,
  input  logic [wordSize-1:0] rxData,
  input  logic                rxLoad,
  output logic [wordSize-1:0] dataOut,
  output logic                dataValid,
  input  logic                dataReady,
  output logic                full,
  output logic                empty,
  output logic [addrBits:0]   count,
  output logic                overrun,
  input  logic                clrOverrun
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                almostFull
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [addrBits:0]   wrPtr;
  logic [addrBits:0]   rdPtr;
  logic [wordSize-1:0] mem [depth];

  logic                pop;
  logic                push;
  logic                drop;
  logic [addrBits:0]   countNext;

  always_comb begin
    empty     = (wrPtr == rdPtr);
    full      = (wrPtr[addrBits-1:0] == rdPtr[addrBits-1:0]) &&
                (wrPtr[addrBits] != rdPtr[addrBits]);
    dataValid = ~empty;
    dataOut   = empty ? '0 : mem[rdPtr[addrBits-1:0]];
  end

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  always_comb begin
    pop  = dataValid & dataReady;
    push = rxLoad & (~full | pop);
    drop = rxLoad & full & ~pop;
  end

  always_comb begin
    countNext = count;
    if (push && !pop) begin
      countNext = count + 1'b1;
    end else if (pop && !push) begin
      countNext = count - 1'b1;
    end
  end

  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= countNext;
    end
  end

  // Storage is not reset; unread slots are never observable.
  always_ff @(posedge sampleClk) begin
    if (push) begin
      mem[wrPtr[addrBits-1:0]] <= rxData;
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clrOverrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef RX_FIFO_ALMOST_FULL_EN
  localparam logic [addrBits:0] AF_THRESH = afThresh[addrBits:0];

  always_ff @(posedge sampleClk or negedge rst_b) begin
    if (!rst_b) begin
      almostFull <= 1'b0;
    end else begin
      almostFull <= (countNext >= AF_THRESH);
    end
  end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo (default parameters).
module tb_rx_fifo;

  logic       sampleClk;
  logic       rst_b;
  logic [7:0] rxData;
  logic       rxLoad;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overrun;
  logic       clrOverrun;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic       almostFull;
`endif

  int passed = 0;
  int total  = 0;

  rx_fifo #(.wordSize(8), .depth(8), .addrBits(3)) dut (
    .sampleClk (sampleClk),
    .rst_b     (rst_b),
    .rxData    (rxData),
    .rxLoad    (rxLoad),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overrun   (overrun),
    .clrOverrun(clrOverrun)
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    .almostFull(almostFull)
`endif
  );

  initial sampleClk = 1'b0;
  always #5 sampleClk = ~sampleClk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge sampleClk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    rxData = d;
    rxLoad = 1'b1;
    step();
    rxLoad = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    rxData = '0; rxLoad = 1'b0; dataReady = 1'b0; clrOverrun = 1'b0;
    #12;
    rst_b = 1'b1;
    step(); step();
    total++; if ({empty, full, dataValid, overrun} !== 4'b1000) $display("FAIL reset_flags got %b want 1000", {empty, full, dataValid, overrun}); else passed++;
    total++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL reset_dataOut got %h want 00", dataOut); else passed++;
  endtask

  task automatic test_single();
    push_word(8'hA5);
    total++; if (dataValid !== 1'b1) $display("FAIL single_valid got %b want 1", dataValid); else passed++;
    total++; if (dataOut !== 8'hA5) $display("FAIL single_dataOut got %h want a5", dataOut); else passed++;
    total++; if (count !== 4'd1) $display("FAIL single_count got %0d want 1", count); else passed++;
    dataReady = 1'b1;
    step();
    dataReady = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL single_empty got %b want 1", empty); else passed++;
    total++; if (count !== 4'd0) $display("FAIL single_count_after got %0d want 0", count); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL single_dataOut_empty got %h want 00", dataOut); else passed++;
    // ready held while empty does nothing
    dataReady = 1'b1;
    step(); step();
    dataReady = 1'b0;
    total++; if ({empty, count} !== {1'b1, 4'd0}) $display("FAIL ready_while_empty got %b/%0d want 1/0", empty, count); else passed++;
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    total++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else passed++;
    total++; if (count !== 4'd8) $display("FAIL fill_count got %0d want 8", count); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL fill_overrun got %b want 0", overrun); else passed++;
    push_word(8'h09);
    total++; if (overrun !== 1'b1) $display("FAIL drop_overrun got %b want 1", overrun); else passed++;
    total++; if (count !== 4'd8) $display("FAIL drop_count got %0d want 8", count); else passed++;
    for (int i = 1; i <= 8; i++) begin
      total++; if (dataOut !== 8'(i)) $display("FAIL drain_word%0d got %h want %h", i, dataOut, 8'(i)); else passed++;
      dataReady = 1'b1;
      step();
    end
    dataReady = 1'b0;
    total++; if ({empty, dataValid} !== 2'b10) $display("FAIL drain_empty got %b want 10", {empty, dataValid}); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b want 1", overrun); else passed++;
    clrOverrun = 1'b1;
    step();
    clrOverrun = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun); else passed++;
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    total++; if (dataOut !== 8'h01) $display("FAIL simul_head got %h want 01", dataOut); else passed++;
    rxData = 8'h55; rxLoad = 1'b1; dataReady = 1'b1;
    step();
    rxLoad = 1'b0; dataReady = 1'b0;
    total++; if (count !== 4'd8) $display("FAIL simul_count got %0d want 8", count); else passed++;
    total++; if ({full, overrun} !== 2'b10) $display("FAIL simul_flags got %b want 10", {full, overrun}); else passed++;
    total++; if (dataOut !== 8'h02) $display("FAIL simul_newhead got %h want 02", dataOut); else passed++;
    for (int i = 2; i <= 9; i++) begin
      logic [7:0] exp;
      exp = (i == 9) ? 8'h55 : 8'(i);
      total++; if (dataOut !== exp) $display("FAIL simul_drain%0d got %h want %h", i, dataOut, exp); else passed++;
      dataReady = 1'b1;
      step();
    end
    dataReady = 1'b0;
    total++; if (empty !== 1'b1) $display("FAIL simul_empty got %b want 1", empty); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    while ((pushed < 20 || q.size() != 0) && cyc < 200) begin
      logic ld, rd, pop_m, acc;
      ld = (pushed < 20);
      rd = ((cyc % 3) != 2);
      total++; if (count !== 4'(q.size())) $display("FAIL wrap_count c%0d got %0d want %0d", cyc, count, q.size()); else passed++;
      total++; if (dataValid !== (q.size() != 0)) $display("FAIL wrap_valid c%0d got %b want %b", cyc, dataValid, q.size() != 0); else passed++;
      if (q.size() != 0) begin
        total++; if (dataOut !== q[0]) $display("FAIL wrap_data c%0d got %h want %h", cyc, dataOut, q[0]); else passed++;
      end
      rxData = 8'h30 + 8'(pushed);
      rxLoad = ld;
      dataReady = rd;
      pop_m = rd && (q.size() != 0);
      acc = ld && (q.size() < 8 || pop_m);
      if (pop_m) begin
        void'(q.pop_front());
        popped++;
      end
      if (acc) begin
        q.push_back(rxData);
        pushed++;
      end
      step();
      cyc++;
    end
    rxLoad = 1'b0; dataReady = 1'b0;
    total++; if (popped != 20) $display("FAIL wrap_popped got %0d want 20", popped); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty); else passed++;
    // drop and clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
    rxData = 8'hEE; rxLoad = 1'b1; clrOverrun = 1'b1;
    step();
    rxLoad = 1'b0;
    total++; if (overrun !== 1'b1) $display("FAIL set_wins got %b want 1", overrun); else passed++;
    step();
    clrOverrun = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL clr_after got %b want 0", overrun); else passed++;
    total++; if (dataOut !== 8'hC0) $display("FAIL set_wins_head got %h want c0", dataOut); else passed++;
  endtask

  task automatic test_async_reset();
    dataReady = 1'b1;
    for (int i = 0; i < 10; i++) step();
    dataReady = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h70 + 8'(i));
    total++; if (count !== 4'd5) $display("FAIL pre_reset_count got %0d want 5", count); else passed++;
    rxLoad = 1'b1; rxData = 8'h99;
    #2;
    rst_b = 1'b0;
    #1;
    total++; if (count !== 4'd0) $display("FAIL async_count got %0d want 0", count); else passed++;
    total++; if ({empty, full, dataValid, overrun} !== 4'b1000) $display("FAIL async_flags got %b want 1000", {empty, full, dataValid, overrun}); else passed++;
    total++; if (dataOut !== 8'h00) $display("FAIL async_dataOut got %h want 00", dataOut); else passed++;
    rxLoad = 1'b0;
    step();
    rst_b = 1'b1;
    step();
    total++; if (empty !== 1'b1) $display("FAIL post_reset_empty got %b want 1", empty); else passed++;
  endtask

`ifdef RX_FIFO_ALMOST_FULL_EN
  task automatic test_almost_full();
    total++; if (almostFull !== 1'b0) $display("FAIL af_reset got %b want 0", almostFull); else passed++;
    for (int i = 0; i < 5; i++) push_word(8'(i));
    total++; if (almostFull !== 1'b0) $display("FAIL af_five got %b want 0", almostFull); else passed++;
    push_word(8'h05);
    total++; if (almostFull !== 1'b1) $display("FAIL af_six got %b want 1", almostFull); else passed++;
    dataReady = 1'b1;
    step();
    dataReady = 1'b0;
    total++; if (almostFull !== 1'b0) $display("FAIL af_pop got %b want 0", almostFull); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_full_simul();
    test_wrap();
    test_async_reset();
`ifdef RX_FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
